// File: rtl/execute_mdu_if.sv
// Issue-side and writeback-side signals of the multiply/divide execute unit.
// The slave modport is the unit itself; master is the issue FIFO / writeback side.
interface execute_mdu_if #(
    parameter int XLEN             = 32,
    parameter int ROB_ID_WIDTH     = 7,
    parameter int PHY_REG_ID_WIDTH = 6
);
    logic                        in_valid;
    logic                        in_ready;
    logic [2:0]                  in_op;
    logic [XLEN-1:0]             in_src1;
    logic [XLEN-1:0]             in_src2;
    logic [ROB_ID_WIDTH-1:0]     in_rob_id;
    logic [PHY_REG_ID_WIDTH-1:0] in_rd_phy;
    logic                        in_rd_enable;
    logic                        in_need_rename;

    logic                        out_valid;
    logic                        out_ready;
    logic [XLEN-1:0]             out_rd_value;
    logic [ROB_ID_WIDTH-1:0]     out_rob_id;
    logic [PHY_REG_ID_WIDTH-1:0] out_rd_phy;
    logic                        out_rd_enable;
    logic                        out_need_rename;

    logic                        fb_enable;
    logic [PHY_REG_ID_WIDTH-1:0] fb_phy_id;
    logic [XLEN-1:0]             fb_value;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_rob_id, in_rd_phy,
               in_rd_enable, in_need_rename, out_ready,
        input  in_ready, out_valid, out_rd_value, out_rob_id, out_rd_phy,
               out_rd_enable, out_need_rename, fb_enable, fb_phy_id, fb_value
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_rob_id, in_rd_phy,
               in_rd_enable, in_need_rename, out_ready,
        output in_ready, out_valid, out_rd_value, out_rob_id, out_rd_phy,
               out_rd_enable, out_need_rename, fb_enable, fb_phy_id, fb_value
    );
endinterface

// File: rtl/execute_mdu.sv
// RV M-extension execute unit: counter-timed multiply, radix-2 restoring
// divide/remainder, writeback ready/valid handshake and abort on flush.
module execute_mdu #(
    parameter int XLEN             = 32,
    parameter int MUL_LATENCY      = 3,
    parameter int ROB_ID_WIDTH     = 7,
    parameter int PHY_REG_ID_WIDTH = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    execute_mdu_if.slave bus
);
    localparam int CNT_W  = $clog2(XLEN);
    localparam int MCNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [MCNT_W-1:0] MUL_LAST = (MUL_LATENCY > 1) ? MCNT_W'(MUL_LATENCY - 2) : '0;
    localparam logic [XLEN-1:0]   XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e state, state_next;
    op_e    op_in, op_q;

    logic              accept, load_done;
    logic [XLEN-1:0]   done_value;
    logic [XLEN-1:0]   mul_value, mul_res_q;
    logic [2*XLEN-1:0] mul_prod;
    logic              a_signed, b_signed;
    logic              in_is_div, in_signed_div, in_div_zero, in_div_ovf;
    logic [XLEN-1:0]   special_value, abs1, abs2;
    logic [XLEN-1:0]   quo_q, dvs_q, fix_value;
    logic [XLEN:0]     rem_q;
    logic [XLEN+1:0]   rem_shift, rem_diff;
    logic              sub_ok, neg_quo_q, neg_rem_q;
    logic [CNT_W-1:0]  div_cnt;
    logic [MCNT_W-1:0] mul_cnt;

    logic [XLEN-1:0]             out_rd_value;
    logic [ROB_ID_WIDTH-1:0]     out_rob_id;
    logic [PHY_REG_ID_WIDTH-1:0] out_rd_phy;
    logic                        out_rd_enable, out_need_rename, out_valid;

    // Handshake and decode of the op presented at the issue FIFO head.
    assign bus.in_ready  = (state == S_IDLE) && !flush && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign op_in         = op_e'(bus.in_op);
    assign in_is_div     = bus.in_op[2];
    assign in_signed_div = bus.in_op[2] && !bus.in_op[0];
    assign in_div_zero   = (bus.in_src2 == '0);
    assign in_div_ovf    = in_signed_div && (bus.in_src1 == XMIN) && (bus.in_src2 == '1);
    // op[1] selects remainder for the divide group.
    assign special_value = in_div_zero ? (bus.in_op[1] ? bus.in_src1 : '1)
                                       : (bus.in_op[1] ? '0 : XMIN);
    assign abs1 = (in_signed_div && bus.in_src1[XLEN-1]) ? -bus.in_src1 : bus.in_src1;
    assign abs2 = (in_signed_div && bus.in_src2[XLEN-1]) ? -bus.in_src2 : bus.in_src2;

    // Full-width product: sign-extend each operand to 2*XLEN and keep the low half of the wrap.
    assign a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    assign b_signed  = (op_in == OP_MULH);
    assign mul_prod  = {{XLEN{a_signed && bus.in_src1[XLEN-1]}}, bus.in_src1}
                     * {{XLEN{b_signed && bus.in_src2[XLEN-1]}}, bus.in_src2};
    assign mul_value = (op_in == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // One restoring step: shift in the next dividend bit, subtract if it does not borrow.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign rem_diff  = rem_shift - {2'b00, dvs_q};
    assign sub_ok    = !rem_diff[XLEN+1];
    assign fix_value = op_q[1] ? (neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0])
                               : (neg_quo_q ? -quo_q : quo_q);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and selection of the value that enters DONE.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
        state_next = state;
        load_done  = 1'b0;
        done_value = '0;
        unique case (state)
            S_IDLE: if (accept) begin
                if (!in_is_div) begin
                    if (MUL_LATENCY == 1) begin
                        state_next = S_DONE;
                        load_done  = 1'b1;
                        done_value = mul_value;
                    end else begin
                        state_next = S_MUL;
                    end
                end else if (in_div_zero || in_div_ovf) begin
                    state_next = S_DONE;
                    load_done  = 1'b1;
                    done_value = special_value;
                end else begin
                    state_next = S_DIV;
                end
            end
            S_MUL: if (mul_cnt == MUL_LAST) begin
                state_next = S_DONE;
                load_done  = 1'b1;
                done_value = mul_res_q;
            end
            S_DIV: if (div_cnt == CNT_W'(XLEN - 1)) state_next = S_FIX;
            S_FIX: begin
                state_next = S_DONE;
                load_done  = 1'b1;
                done_value = fix_value;
            end
            S_DONE: if (bus.out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // Operand/tag capture, iteration counters, divide datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q            <= OP_MUL;
            mul_res_q       <= '0;
            quo_q           <= '0;
            rem_q           <= '0;
            dvs_q           <= '0;
            neg_quo_q       <= 1'b0;
            neg_rem_q       <= 1'b0;
            mul_cnt         <= '0;
            div_cnt         <= '0;
            out_rd_value    <= '0;
            out_rob_id      <= '0;
            out_rd_phy      <= '0;
            out_rd_enable   <= 1'b0;
            out_need_rename <= 1'b0;
        end else begin
            if (accept) begin
                op_q            <= op_in;
                mul_res_q       <= mul_value;
                quo_q           <= abs1;
                rem_q           <= '0;
                dvs_q           <= abs2;
                neg_quo_q       <= in_signed_div && (bus.in_src1[XLEN-1] ^ bus.in_src2[XLEN-1]);
                neg_rem_q       <= in_signed_div && bus.in_src1[XLEN-1];
                mul_cnt         <= '0;
                div_cnt         <= '0;
                out_rob_id      <= bus.in_rob_id;
                out_rd_phy      <= bus.in_rd_phy;
                out_rd_enable   <= bus.in_rd_enable;
                out_need_rename <= bus.in_need_rename;
            end
            if (state == S_MUL) mul_cnt <= mul_cnt + 1'b1;
            if (state == S_DIV) begin
                quo_q   <= {quo_q[XLEN-2:0], sub_ok};
                rem_q   <= sub_ok ? rem_diff[XLEN:0] : rem_shift[XLEN:0];
                div_cnt <= div_cnt + 1'b1;
            end
            if (load_done && !flush) out_rd_value <= done_value;
        end
    end

    assign out_valid           = (state == S_DONE);
    assign bus.out_valid       = out_valid;
    assign bus.out_rd_value    = out_rd_value;
    assign bus.out_rob_id      = out_rob_id;
    assign bus.out_rd_phy      = out_rd_phy;
    assign bus.out_rd_enable   = out_rd_enable;
    assign bus.out_need_rename = out_need_rename;
    assign bus.fb_enable       = out_valid && bus.out_ready && out_rd_enable
                               && out_need_rename && !flush;
    assign bus.fb_phy_id       = out_rd_phy;
    assign bus.fb_value        = out_rd_value;
endmodule

// File: tb/tb_execute_mdu.sv
// Directed self-checking bench for execute_mdu (XLEN=32, MUL_LATENCY=3).
module tb_execute_mdu;
    localparam int XLEN = 32;
    localparam int LAT  = 3;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_vec = 0;
    int   n_err = 0;
    logic [6:0] next_rob = 7'd1;

    always #5 clk = ~clk;

    execute_mdu_if #(.XLEN(XLEN), .ROB_ID_WIDTH(7), .PHY_REG_ID_WIDTH(6)) bus ();

    execute_mdu #(
        .XLEN(XLEN), .MUL_LATENCY(LAT), .ROB_ID_WIDTH(7), .PHY_REG_ID_WIDTH(6)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    // Counts one comparison and reports it when observed differs from expected.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one op for a single cycle; returns just after the accepting edge.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [6:0] rob, input logic [5:0] phy,
                         input logic rd_en, input logic nr);
        @(negedge clk);
        bus.in_valid       = 1'b1;
        bus.in_op          = op;
        bus.in_src1        = a;
        bus.in_src2        = b;
        bus.in_rob_id      = rob;
        bus.in_rd_phy      = phy;
        bus.in_rd_enable   = rd_en;
        bus.in_need_rename = nr;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid and checks the cycle count since accept.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.out_valid) lat = k;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    // Full op with out_ready held high: latency, value, tag and the feedback pulse.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_val);
        logic [6:0] rob;
        rob      = next_rob;
        next_rob = next_rob + 7'd1;
        issue(tag, op, a, b, rob, 6'(rob + 7'd3), 1'b1, 1'b1);
        wait_valid(tag, exp_lat);
        check({tag, "_value"}, 64'(bus.out_rd_value), 64'(exp_val));
        check({tag, "_rob_id"}, 64'(bus.out_rob_id), 64'(rob));
        check({tag, "_fb_enable"}, 64'(bus.fb_enable), 64'd1);
        check({tag, "_fb_value"}, 64'(bus.fb_value), 64'(exp_val));
        @(posedge clk);
        #1;
    endtask

    // Result held with out_ready low for three cycles, then released.
    task automatic stall_op(input string tag, input logic nr, input logic [6:0] rob,
                            input logic [5:0] phy);
        bus.out_ready = 1'b0;
        issue(tag, OP_MUL, 32'h0000_1111, 32'h0000_0010, rob, phy, 1'b1, nr);
        wait_valid(tag, LAT);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_value"}, 64'(bus.out_rd_value), 64'h0001_1110);
            check({tag, "_hold_rob"}, 64'(bus.out_rob_id), 64'(rob));
            check({tag, "_hold_phy"}, 64'(bus.out_rd_phy), 64'(phy));
            check({tag, "_hold_fb"}, 64'(bus.fb_enable), 64'd0);
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check({tag, "_release_fb"}, 64'(bus.fb_enable), 64'(nr));
        check({tag, "_release_fb_phy"}, 64'(bus.fb_phy_id), 64'(phy));
        @(negedge clk);
        check({tag, "_after_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_after_fb"}, 64'(bus.fb_enable), 64'd0);
        check({tag, "_after_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int hits;
        rst                = 1'b1;
        flush              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_op          = '0;
        bus.in_src1        = '0;
        bus.in_src2        = '0;
        bus.in_rob_id      = '0;
        bus.in_rd_phy      = '0;
        bus.in_rd_enable   = 1'b0;
        bus.in_need_rename = 1'b0;
        bus.out_ready      = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_value", 64'(bus.out_rd_value), 64'd0);
        check("rst_rob_id", 64'(bus.out_rob_id), 64'd0);
        check("rst_fb_enable", 64'(bus.fb_enable), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Multiplies
        run_op("mul",     OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, LAT, 32'hFFFF_FFEB);
        run_op("mulh",    OP_MULH,   32'h8000_0000, 32'h8000_0000, LAT, 32'h4000_0000);
        run_op("mulhu",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 32'hFFFF_FFFE);
        run_op("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, LAT, 32'hFFFF_FFFF);

        // Iterative divides
        run_op("div_neg", OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, XLEN + 2, 32'hFFFF_FFFD);
        run_op("rem_neg", OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, XLEN + 2, 32'hFFFF_FFFF);
        run_op("divu",    OP_DIVU, 32'd100, 32'd7, XLEN + 2, 32'd14);
        run_op("remu",    OP_REMU, 32'd100, 32'd7, XLEN + 2, 32'd2);
        run_op("div_nd",  OP_DIV,  32'd7, 32'hFFFF_FFFE, XLEN + 2, 32'hFFFF_FFFD);
        run_op("rem_nd",  OP_REM,  32'd7, 32'hFFFF_FFFE, XLEN + 2, 32'd1);

        // Divide by zero and signed overflow
        run_op("divu_z",  OP_DIVU, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("remu_z",  OP_REMU, 32'h0000_1234, 32'd0, 1, 32'h0000_1234);
        run_op("rem_z",   OP_REM,  32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9);
        run_op("div_ovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_op("rem_ovf", OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);

        // Flush during a divide at T+10
        issue("flush_div", OP_DIV, 32'd100, 32'd3, 7'h40, 6'h20, 1'b1, 1'b1);
        hits = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bus.out_valid || bus.fb_enable) hits++;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_cycle_in_ready", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid || bus.fb_enable) hits++;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_next_in_ready", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid || bus.fb_enable) hits++;
            @(negedge clk);
        end
        check("flush_no_result", 64'(hits), 64'd0);
        run_op("post_flush_mul", OP_MUL, 32'd6, 32'd7, LAT, 32'd42);

        // Writeback backpressure, with and without rename
        stall_op("stall_nr1", 1'b1, 7'h55, 6'h2A);
        stall_op("stall_nr0", 1'b0, 7'h56, 6'h15);

        // Reset during a divide at T+5
        issue("rst_div", OP_DIV, 32'd1000, 32'd7, 7'h33, 6'h11, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_value", 64'(bus.out_rd_value), 64'd0);
        check("mid_rst_rob", 64'(bus.out_rob_id), 64'd0);
        check("mid_rst_phy", 64'(bus.out_rd_phy), 64'd0);
        check("mid_rst_rd_en", 64'(bus.out_rd_enable), 64'd0);
        check("mid_rst_rename", 64'(bus.out_need_rename), 64'd0);
        check("mid_rst_fb", 64'(bus.fb_enable), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        run_op("post_rst_divu", OP_DIVU, 32'd1000, 32'd7, XLEN + 2, 32'd142);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so a wedged DUT can never hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/execute_mdu.md
Name: execute_mdu

Overview:
Parametrised multiply/divide execute unit (RV M-extension) sitting beside the single-cycle ALU execute stage, between the issue MDU FIFO and the writeback port.
Multiplies complete in a configurable, counter-timed number of cycles. Divides and remainders use an iterative radix-2 restoring FSM.
Unlike the ALU it has multi-cycle state, a writeback ready/valid handshake, and abort on commit flush.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_LATENCY, 3, cycles from accept to out_valid for MUL* ops (>=1)
ROB_ID_WIDTH, 7, ROB index width
PHY_REG_ID_WIDTH, 6, physical register index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  issue FIFO head valid
in_ready  out  1  pop issue FIFO (accept when in_valid && in_ready)
in_op  in  3  0 mul,1 mulh,2 mulhsu,3 mulhu,4 div,5 divu,6 rem,7 remu
in_src1  in  XLEN  rs1 value
in_src2  in  XLEN  rs2 value
in_rob_id  in  ROB_ID_WIDTH  ROB entry
in_rd_phy  in  PHY_REG_ID_WIDTH  destination physical reg
in_rd_enable  in  1  instruction writes rd
in_need_rename  in  1  rd was renamed
flush  in  1  commit_feedback enable && flush
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts
out_rd_value  out  XLEN  result
out_rob_id  out  ROB_ID_WIDTH  captured rob_id
out_rd_phy  out  PHY_REG_ID_WIDTH  captured rd_phy
out_rd_enable  out  1  captured
out_need_rename  out  1  captured
fb_enable  out  1  bypass feedback valid
fb_phy_id  out  PHY_REG_ID_WIDTH  = out_rd_phy
fb_value  out  XLEN  = out_rd_value

Behaviour:
- Reset: state IDLE; out_valid=0, out_rd_value=0, out_rob_id=0, out_rd_phy=0, out_rd_enable=0, out_need_rename=0, fb_enable=0; counters cleared.
- States: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state==IDLE) && !flush && !rst. No accept in the cycle DONE completes; in_ready rises the following cycle.
- On accept in cycle T, latch op, operands and tags.
  - MUL*: go to MUL. Full 2*XLEN product computed. Counter counts to MUL_LATENCY-1, then DONE; out_valid is first high in T+MUL_LATENCY.
  - mul returns the low XLEN bits. mulh is signed x signed, mulhsu is signed x unsigned, mulhu is unsigned x unsigned; all three return the high XLEN bits.
  - DIV*, divisor==0: go straight to DONE with out_valid in T+1. Quotient = all ones; rem = src1.
  - DIV*, signed op with src1==MIN and src2==-1: out_valid in T+1. Quotient = MIN; rem = 0.
  - DIV*, otherwise: go to DIV. Signed ops use magnitudes. One quotient bit per cycle for XLEN cycles (T+1..T+XLEN).
  - FIX (T+XLEN+1): negate quotient if the operand signs differ; negate remainder if the dividend is negative. Then DONE; out_valid is first high in T+XLEN+2.
- DONE: outputs registered and held stable while out_valid && !out_ready. On out_valid && out_ready, next state is IDLE and out_valid=0.
- fb_enable = out_valid && out_ready && out_rd_enable && out_need_rename && !flush. It pulses exactly once per result.
- flush (any state, any cycle): next state IDLE, out_valid=0 next cycle, no accept that cycle. fb_enable and handshake are suppressed in the flush cycle. In-flight op is discarded without writeback.
- rst has priority over flush; rst mid-divide returns to the reset values next cycle.
- All arithmetic is modulo XLEN. Intermediate remainder is XLEN+1 bits. No X on outputs while out_valid=0 (drive held/zero values).

Test Plan:
- XLEN=32, MUL_LATENCY=3, mul 7 x 0xFFFFFFFD accepted at T -> out_valid first at T+3, out_rd_value=0xFFFFFFEB; mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- div 0xFFFFFFF9 (-7) / 2 at T -> out_valid at T+34, value 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; divu 100/7 -> 14, remu -> 2.
- divu 0x1234 / 0 -> out_valid at T+1, 0xFFFFFFFF; remu -> 0x1234; div 0x80000000 / 0xFFFFFFFF -> 0x80000000, rem -> 0, both at T+1.
- Accept div, assert flush at T+10 -> out_valid never rises, fb_enable stays 0, in_ready=1 at T+11, and a following mul completes normally.
- Result ready with out_ready=0 for 3 cycles -> value and tags stable, fb_enable=0, in_ready=0; out_ready=1 -> single fb_enable pulse (rd_enable=1, need_rename=1), in_ready=1 next cycle. Repeat with need_rename=0 -> fb_enable never asserts.
- rst asserted during DIV at T+5 -> all outputs at reset values at T+6, in_ready=1 after rst drops.
